// File: rtl/gpio_status_sequencer_pkg.sv
// Shared types and constants for the GPIO status sequencer.
// The sequencer, its arbiter and the bench all import this package.
package gpio_status_sequencer_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_HOLD = 1'b1
  } seq_state_t;

  localparam logic [15:0] STATUS_BASE = 16'hAB00;

endpackage

// File: rtl/gpio_status_sequencer_rr_arbiter.sv
// Combinational round-robin search. It returns the first asserted request at or after ptr,
// wrapping modulo N. The pointer register itself lives in the sequencer.
module rr_arbiter #(
  parameter int N = 4
) (
  input  logic [N-1:0]         req,
  input  logic [$clog2(N)-1:0] ptr,
  output logic [N-1:0]         gnt_onehot,
  output logic [$clog2(N)-1:0] gnt_idx,
  output logic                 any
);

  localparam int IW = $clog2(N);

  // The wrap uses an explicit subtract so that a non-power-of-two N stays in range.
  always_comb begin
    int unsigned cand;
    cand    = 0;
    gnt_idx = '0;
    any     = 1'b0;
    for (int k = 0; k < N; k++) begin
      cand = 32'(ptr) + 32'(k);
      if (cand >= 32'(N)) cand = cand - 32'(N);
      if (!any && req[IW'(cand)]) begin
        any     = 1'b1;
        gnt_idx = IW'(cand);
      end
    end
  end

  assign gnt_onehot = any ? (N'(1) << gnt_idx) : '0;

endmodule

// File: rtl/gpio_status_sequencer.sv
// Shares the user status pads between several requesters.
// Each granted word is held on the pads for HOLD_CYCLES cycles so that no code is lost.
module gpio_status_sequencer
  import gpio_status_sequencer_pkg::*;
#(
  parameter int NREQ        = 4,
  parameter int WIDTH       = 16,
  parameter int HOLD_CYCLES = 64
) (
  input  logic                    wb_clk_i,
  input  logic                    resetb,
  input  logic                    cfg_en,
  input  logic [NREQ-1:0]         req_valid,
  input  logic [NREQ*WIDTH-1:0]   req_data,
  output logic [NREQ-1:0]         req_ready,
  output logic [WIDTH-1:0]        status_out,
  output logic [WIDTH-1:0]        status_oeb,
  output logic                    busy,
  output logic [$clog2(NREQ)-1:0] grant_id
);

  localparam int IW = $clog2(NREQ);
  localparam int CW = $clog2(HOLD_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LOAD = CW'(HOLD_CYCLES - 1);

  seq_state_t       state, state_nxt;
  logic [CW-1:0]    cnt, cnt_nxt;
  logic [IW-1:0]    ptr, gnt_idx;
  logic [NREQ-1:0]  gnt_onehot;
  logic             any, take, cfg_q;
  logic [WIDTH-1:0] gnt_word;

  rr_arbiter #(.N(NREQ)) u_arb (
    .req        (req_valid),
    .ptr        (ptr),
    .gnt_onehot (gnt_onehot),
    .gnt_idx    (gnt_idx),
    .any        (any)
  );

  always_comb begin
    gnt_word = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (gnt_idx == IW'(i)) gnt_word = req_data[i*WIDTH +: WIDTH];
    end
  end

  // A grant is taken from IDLE, or back-to-back on the last HOLD cycle.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    take      = 1'b0;
    case (state)
      ST_IDLE: begin
        if (cfg_en && any) take = 1'b1;
      end
      ST_HOLD: begin
        if (!cfg_en) begin
          state_nxt = ST_IDLE;
          cnt_nxt   = '0;
        end else if (cnt != '0) begin
          cnt_nxt = cnt - 1'b1;
        end else if (any) begin
          take = 1'b1;
        end else begin
          state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
    if (take) begin
      state_nxt = ST_HOLD;
      cnt_nxt   = CNT_LOAD;
    end
  end

  // The grant pulse is gated by reset so that it cannot appear while the block is held in reset.
  assign req_ready  = (take && resetb) ? gnt_onehot : '0;
  assign busy       = (state == ST_HOLD);
  assign status_oeb = {WIDTH{~cfg_q}};

  always_ff @(posedge wb_clk_i or negedge resetb) begin
    if (!resetb) begin
      state      <= ST_IDLE;
      cnt        <= '0;
      ptr        <= '0;
      status_out <= '0;
      grant_id   <= '0;
      cfg_q      <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      cfg_q <= cfg_en;
      if (take) begin
        status_out <= gnt_word;
        grant_id   <= gnt_idx;
        ptr        <= (gnt_idx == IW'(NREQ - 1)) ? '0 : gnt_idx + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_gpio_status_sequencer.sv
// Self-checking bench for gpio_status_sequencer. A behavioural display model is compared every cycle.
// Directed literal checks cover reset, hold length, round-robin order, cfg_en drop and HOLD_CYCLES=1.
module tb_gpio_status_sequencer;
  import gpio_status_sequencer_pkg::*;

  localparam int NREQ  = 4;
  localparam int WIDTH = 16;
  localparam int HOLD  = 64;
  localparam logic [15:0] CODE0 = STATUS_BASE | 16'h0060;
  localparam logic [15:0] CODE1 = STATUS_BASE | 16'h0061;

  logic clock  = 1'b0;
  logic resetb = 1'b0;
  logic cfg_en = 1'b0;
  logic [NREQ-1:0]       req_valid = '0;
  logic [NREQ*WIDTH-1:0] req_data  = '0;
  logic [NREQ-1:0]       req_ready;
  logic [WIDTH-1:0]      status_out, status_oeb;
  logic                  busy;
  logic [1:0]            grant_id;

  logic cfg_en1 = 1'b0;
  logic [NREQ-1:0]       req_valid1 = '0;
  logic [NREQ*WIDTH-1:0] req_data1  = '0;
  logic [NREQ-1:0]       req_ready1;
  logic [WIDTH-1:0]      status_out1, status_oeb1;
  logic                  busy1;
  logic [1:0]            grant_id1;

  logic [NREQ-1:0] rearm = '0;
  logic [NREQ-1:0] ready_neg = '0;
  int n_checks = 0;
  int n_errors = 0;

  int          m_left = 0;
  logic [15:0] m_word = '0;
  int          m_id   = 0;
  int          m_ptr  = 0;
  logic        m_cfg  = 1'b0;
  int          m_g;

  initial forever #5 clock = ~clock;

  gpio_status_sequencer #(.NREQ(NREQ), .WIDTH(WIDTH), .HOLD_CYCLES(HOLD)) dut (
    .wb_clk_i(clock), .resetb(resetb), .cfg_en(cfg_en), .req_valid(req_valid),
    .req_data(req_data), .req_ready(req_ready), .status_out(status_out),
    .status_oeb(status_oeb), .busy(busy), .grant_id(grant_id)
  );

  gpio_status_sequencer #(.NREQ(NREQ), .WIDTH(WIDTH), .HOLD_CYCLES(1)) dut1 (
    .wb_clk_i(clock), .resetb(resetb), .cfg_en(cfg_en1), .req_valid(req_valid1),
    .req_data(req_data1), .req_ready(req_ready1), .status_out(status_out1),
    .status_oeb(status_oeb1), .busy(busy1), .grant_id(grant_id1)
  );

  function automatic int pick(logic [NREQ-1:0] v, int p);
    logic [NREQ-1:0] t;
    for (int k = 0; k < NREQ; k++) begin
      t = v >> ((p + k) % NREQ);
      if (t[0]) return (p + k) % NREQ;
    end
    return -1;
  endfunction

  function automatic logic [15:0] word_of(logic [NREQ*WIDTH-1:0] d, int g);
    logic [NREQ*WIDTH-1:0] t;
    t = d >> (g * WIDTH);
    return t[15:0];
  endfunction

  always_comb m_g = pick(req_valid, m_ptr);

  // The model counts the display cycles left for the current word; a new word may be taken once at most one remains.
  always @(posedge clock or negedge resetb) begin
    if (!resetb) begin
      m_left <= 0;
      m_word <= '0;
      m_id   <= 0;
      m_ptr  <= 0;
      m_cfg  <= 1'b0;
    end else begin
      if (cfg_en && m_left <= 1 && m_g >= 0) begin
        m_word <= word_of(req_data, m_g);
        m_id   <= m_g;
        m_ptr  <= (m_g + 1) % NREQ;
        m_left <= HOLD;
      end else if (!cfg_en) begin
        m_left <= 0;
      end else if (m_left > 0) begin
        m_left <= m_left - 1;
      end
      m_cfg <= cfg_en;
    end
  end

  always @(negedge clock) ready_neg <= req_ready;

  task automatic check_output(string name, logic [31:0] got, logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic compare_loop();
    logic [NREQ-1:0] exp_ready;
    forever begin
      @(negedge clock);
      exp_ready = '0;
      if (resetb && cfg_en && m_left <= 1 && m_g >= 0) exp_ready = 4'b0001 << m_g;
      check_output("model_ready", 32'(req_ready), 32'(exp_ready));
      check_output("model_status", 32'(status_out), 32'(m_word));
      check_output("model_busy", 32'(busy), 32'(m_left > 0));
      check_output("model_grant_id", 32'(grant_id), 32'(m_id));
      check_output("model_oeb", 32'(status_oeb), m_cfg ? 32'h0 : 32'hFFFF);
    end
  endtask

  // One clock cycle; a requester that was granted drops its request unless it is set to rearm.
  task automatic apply_stimulus();
    @(posedge clock);
    #1;
    for (int i = 0; i < NREQ; i++) begin
      if (ready_neg[2'(i)] && !rearm[2'(i)]) req_valid[2'(i)] = 1'b0;
    end
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic set_word(int i, logic [15:0] w);
    req_data = (req_data & ~({{(NREQ*WIDTH-16){1'b0}}, 16'hFFFF} << (i * WIDTH)))
               | ({{(NREQ*WIDTH-16){1'b0}}, w} << (i * WIDTH));
  endtask

  initial begin
    int n;
    logic [15:0] prev;
    fork
      compare_loop();
    join_none

    cfg_en = 1'b1;
    set_word(0, CODE0);
    req_valid[0] = 1'b1;
    #2;
    check_output("reset_status", 32'(status_out), 32'h0);
    check_output("reset_oeb", 32'(status_oeb), 32'hFFFF);
    check_output("reset_busy", 32'(busy), 32'h0);
    check_output("reset_grant_id", 32'(grant_id), 32'h0);
    check_output("reset_ready_gated", 32'(req_ready), 32'h0);
    repeat (2) apply_stimulus();

    resetb = 1'b1;
    settle();
    check_output("t1_grant_pulse", 32'(req_ready), 32'h1);
    apply_stimulus();
    check_output("t1_status", 32'(status_out), 32'(CODE0));
    check_output("t1_busy", 32'(busy), 32'h1);
    check_output("t1_ready_low", 32'(req_ready), 32'h0);
    repeat (HOLD - 1) apply_stimulus();
    check_output("t1_last_hold_busy", 32'(busy), 32'h1);
    apply_stimulus();
    check_output("t1_idle_busy", 32'(busy), 32'h0);
    check_output("t1_status_kept", 32'(status_out), 32'(CODE0));

    set_word(0, CODE0);
    req_valid[0] = 1'b1;
    settle();
    check_output("t2_grant0", 32'(req_ready), 32'h1);
    apply_stimulus();
    check_output("t2_status0", 32'(status_out), 32'(CODE0));
    repeat (5) apply_stimulus();
    n = 5;
    set_word(1, CODE1);
    req_valid[1] = 1'b1;
    while (status_out == CODE0 && n < 200) begin
      apply_stimulus();
      n++;
    end
    check_output("t2_hold_len", 32'(n), 32'(HOLD));
    check_output("t2_status1", 32'(status_out), 32'(CODE1));
    check_output("t2_grant_id", 32'(grant_id), 32'h1);
    check_output("t2_no_gap_busy", 32'(busy), 32'h1);
    repeat (10) apply_stimulus();

    for (int i = 0; i < NREQ; i++) set_word(i, 16'h00A0 + 16'(i));
    rearm     = '1;
    req_valid = '1;
    resetb    = 1'b0;
    settle();
    check_output("t5_async_status", 32'(status_out), 32'h0);
    check_output("t5_async_busy", 32'(busy), 32'h0);
    check_output("t5_async_oeb", 32'(status_oeb), 32'hFFFF);
    check_output("t5_async_grant_id", 32'(grant_id), 32'h0);
    check_output("t5_async_ready", 32'(req_ready), 32'h0);
    apply_stimulus();
    resetb = 1'b1;
    settle();
    check_output("t5_lowest_first", 32'(req_ready), 32'h1);
    apply_stimulus();
    check_output("t5_status", 32'(status_out), 32'h00A0);
    check_output("t5_grant_id", 32'(grant_id), 32'h0);

    for (int k = 1; k <= 4; k++) begin
      n    = 0;
      prev = status_out;
      do begin
        apply_stimulus();
        n++;
      end while (status_out == prev && n < 200);
      check_output("t3_interval", 32'(n), 32'(HOLD));
      check_output("t3_grant_id", 32'(grant_id), 32'(k % 4));
      check_output("t3_status", 32'(status_out), 32'h00A0 + 32'(k % 4));
    end

    repeat (9) apply_stimulus();
    cfg_en = 1'b0;
    settle();
    check_output("t4_no_ready", 32'(req_ready), 32'h0);
    apply_stimulus();
    check_output("t4_busy_low", 32'(busy), 32'h0);
    check_output("t4_oeb_tristate", 32'(status_oeb), 32'hFFFF);
    check_output("t4_status_kept", 32'(status_out), 32'h00A0);
    repeat (5) apply_stimulus();
    cfg_en = 1'b1;
    settle();
    check_output("t4_regrant", 32'(req_ready), 32'h2);
    apply_stimulus();
    check_output("t4_status", 32'(status_out), 32'h00A1);
    check_output("t4_grant_id", 32'(grant_id), 32'h1);
    check_output("t4_busy", 32'(busy), 32'h1);
    check_output("t4_oeb_driven", 32'(status_oeb), 32'h0);
    rearm     = '0;
    req_valid = '0;
    repeat (HOLD + 4) apply_stimulus();
    check_output("t4_final_idle", 32'(busy), 32'h0);

    cfg_en1    = 1'b1;
    req_valid1 = 4'b0100;
    req_data1  = 64'h6000 << 32;
    settle();
    check_output("t6_first_ready", 32'(req_ready1), 32'h4);
    for (int j = 1; j <= 8; j++) begin
      apply_stimulus();
      check_output("t6_status", 32'(status_out1), 32'h6000 + 32'(j - 1));
      check_output("t6_ready", 32'(req_ready1), 32'h4);
      check_output("t6_busy", 32'(busy1), 32'h1);
      check_output("t6_grant_id", 32'(grant_id1), 32'h2);
      check_output("t6_oeb", 32'(status_oeb1), 32'h0);
      req_data1 = (64'h6000 + 64'(j)) << 32;
    end
    cfg_en1    = 1'b0;
    req_valid1 = '0;
    repeat (2) apply_stimulus();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
